// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: merges per-requester freeze depths into a
// thermometer hold vector and sequences jump flushes, with stall statistics.
module pipe_hold_ctrl #(
    parameter int NUM_REQ       = 6,
    parameter int NUM_STAGE     = 4,
    parameter int FLUSH_CYC     = 2,
    parameter int STALL_TIMEOUT = 255,
    parameter int CNT_W         = 16,
    localparam int DW = ($clog2(NUM_STAGE + 1) > 1) ? $clog2(NUM_STAGE + 1) : 1,
    localparam int SW = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    hold_req_i,
    input  logic [NUM_REQ*DW-1:0] hold_depth_i,
    input  logic                  jump_flag_i,
    input  logic                  stat_clr_i,
    output logic [NUM_STAGE-1:0]  hold_o,
    output logic                  flush_o,
    output logic [SW-1:0]         hold_src_o,
    output logic                  timeout_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    typedef enum logic [1:0] {RUN, FLUSH, STALL} state_t;

    state_t               state_q, state_d;
    logic [3:0]           fcnt_q, fcnt_d;
    logic [15:0]          consec_q, consec_d;
    logic [SW-1:0]        src_q;
    logic                 timeout_q, timeout_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [NUM_STAGE-1:0] req_hold;
    logic [SW-1:0]        src_sel;
    logic                 any_req;
    logic                 flush_act;
    logic                 stall;

    // Scan from the top so the lowest active index wins; depths beyond
    // NUM_STAGE clamp naturally because only NUM_STAGE bits exist.
    always_comb begin
        req_hold = '0;
        src_sel  = '0;
        any_req  = 1'b0;
        for (int r = NUM_REQ - 1; r >= 0; r--) begin
            if (hold_req_i[r] && (hold_depth_i[r*DW +: DW] != '0)) begin
                any_req = 1'b1;
                src_sel = SW'(r);
                for (int k = 0; k < NUM_STAGE; k++) begin
                    if (int'(hold_depth_i[r*DW +: DW]) > k) req_hold[k] = 1'b1;
                end
            end
        end
    end

    // A jump flushes in its own cycle; reset kills any flush immediately.
    assign flush_act = rst_n & (jump_flag_i | (state_q == FLUSH));
    assign flush_o   = flush_act;
    assign hold_o    = flush_act ? {NUM_STAGE{1'b1}} : req_hold;
    assign stall     = |hold_o;

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (jump_flag_i) begin
            if (FLUSH_CYC > 1) begin
                state_d = FLUSH;
                fcnt_d  = 4'(FLUSH_CYC - 1);
            end else begin
                state_d = any_req ? STALL : RUN;
                fcnt_d  = '0;
            end
        end else begin
            case (state_q)
                FLUSH: begin
                    if (fcnt_q > 4'd1) begin
                        fcnt_d = fcnt_q - 4'd1;
                    end else begin
                        fcnt_d  = '0;
                        state_d = any_req ? STALL : RUN;
                    end
                end
                RUN:     if (any_req)  state_d = STALL;
                STALL:   if (!any_req) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        if (!stall)                                consec_d = '0;
        else if (consec_q >= 16'(STALL_TIMEOUT))   consec_d = consec_q;
        else                                       consec_d = consec_q + 16'd1;

        if (stat_clr_i)                            timeout_d = 1'b0;
        else                                       timeout_d = timeout_q | (consec_d == 16'(STALL_TIMEOUT));

        if (stat_clr_i)                            cnt_d = '0;
        else if (stall)                            cnt_d = cnt_q + CNT_W'(1);
        else                                       cnt_d = cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            fcnt_q    <= '0;
            consec_q  <= '0;
            src_q     <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            consec_q  <= consec_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            if (any_req) src_q <= src_sel;
        end
    end

    assign hold_src_o  = src_q;
    assign timeout_o   = timeout_q;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed bench for pipe_hold_ctrl: a default instance and a small-counter
// instance (STALL_TIMEOUT=3, CNT_W=4) share the same stimulus.
module tb_pipe_hold_ctrl;
    localparam int NR = 6;
    localparam int NS = 4;
    localparam int DW = 3;
    localparam int SW = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NR-1:0]  hold_req;
    logic [NR*DW-1:0] hold_depth;
    logic           jump_flag;
    logic           stat_clr;

    logic [NS-1:0]  d_hold,    s_hold;
    logic           d_flush,   s_flush;
    logic [SW-1:0]  d_src,     s_src;
    logic           d_timeout, s_timeout;
    logic [15:0]    d_cnt;
    logic [3:0]     s_cnt;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    pipe_hold_ctrl u_def (
        .clk(clk), .rst_n(rst_n), .hold_req_i(hold_req), .hold_depth_i(hold_depth),
        .jump_flag_i(jump_flag), .stat_clr_i(stat_clr), .hold_o(d_hold), .flush_o(d_flush),
        .hold_src_o(d_src), .timeout_o(d_timeout), .stall_cnt_o(d_cnt)
    );

    pipe_hold_ctrl #(.STALL_TIMEOUT(3), .CNT_W(4)) u_small (
        .clk(clk), .rst_n(rst_n), .hold_req_i(hold_req), .hold_depth_i(hold_depth),
        .jump_flag_i(jump_flag), .stat_clr_i(stat_clr), .hold_o(s_hold), .flush_o(s_flush),
        .hold_src_o(s_src), .timeout_o(s_timeout), .stall_cnt_o(s_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change 1ns after the rising edge; checks happen at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input int d);
        hold_req[r] = 1'b1;
        hold_depth[r*DW +: DW] = 3'(d);
    endtask

    task automatic clr_req();
        hold_req   = '0;
        hold_depth = '0;
    endtask

    initial begin
        rst_n = 1'b0; jump_flag = 1'b0; stat_clr = 1'b0;
        clr_req();
        #2;
        set_req(2, 2);
        jump_flag = 1'b1;
        #1;
        chk("rst_hold_live", 32'(d_hold), 32'h3);
        chk("rst_flush", 32'(d_flush), 32'h0);
        chk("rst_src", 32'(d_src), 32'h0);
        chk("rst_timeout", 32'(d_timeout), 32'h0);
        chk("rst_cnt", 32'(d_cnt), 32'h0);
        jump_flag = 1'b0;
        clr_req();
        #4 rst_n = 1'b1;

        // single requester depth 1
        next_cycle(); set_req(2, 1);
        #4 chk("req2_hold", 32'(d_hold), 32'h1);
        chk("req2_flush", 32'(d_flush), 32'h0);
        next_cycle(); clr_req();
        #4 chk("req2_src", 32'(d_src), 32'h2);
        chk("idle_hold", 32'(d_hold), 32'h0);

        // two requesters, lowest index wins, widest depth sets hold
        next_cycle(); set_req(0, 3); set_req(5, 1);
        #4 chk("multi_hold", 32'(d_hold), 32'h7);
        next_cycle(); clr_req();
        #4 chk("multi_src", 32'(d_src), 32'h0);

        // depth 0 ignored, depth 7 clamped
        next_cycle(); set_req(0, 0); set_req(1, 7);
        #4 chk("clamp_hold", 32'(d_hold), 32'hF);
        chk("clamp_flush", 32'(d_flush), 32'h0);
        next_cycle(); clr_req();
        #4 chk("zero_depth_src", 32'(d_src), 32'h1);

        // single jump
        next_cycle(); jump_flag = 1'b1;
        #4 chk("jmp_t_flush", 32'(d_flush), 32'h1);
        chk("jmp_t_hold", 32'(d_hold), 32'hF);
        next_cycle(); jump_flag = 1'b0;
        #4 chk("jmp_t1_flush", 32'(d_flush), 32'h1);
        chk("jmp_t1_hold", 32'(d_hold), 32'hF);
        next_cycle();
        #4 chk("jmp_t2_flush", 32'(d_flush), 32'h0);
        chk("jmp_t2_hold", 32'(d_hold), 32'h0);

        // back-to-back jumps reload the flush
        next_cycle(); jump_flag = 1'b1;
        #4 chk("rj_t_flush", 32'(d_flush), 32'h1);
        next_cycle();
        #4 chk("rj_t1_flush", 32'(d_flush), 32'h1);
        next_cycle(); jump_flag = 1'b0;
        #4 chk("rj_t2_flush", 32'(d_flush), 32'h1);
        next_cycle();
        #4 chk("rj_t3_flush", 32'(d_flush), 32'h0);
        chk("rj_t3_hold", 32'(d_hold), 32'h0);

        // request during flush leads to stall after it
        next_cycle(); jump_flag = 1'b1; set_req(2, 1);
        #4 chk("fs_t_hold", 32'(d_hold), 32'hF);
        next_cycle(); jump_flag = 1'b0;
        #4 chk("fs_t1_flush", 32'(d_flush), 32'h1);
        next_cycle();
        #4 chk("fs_t2_flush", 32'(d_flush), 32'h0);
        chk("fs_t2_hold", 32'(d_hold), 32'h1);
        chk("fs_t2_src", 32'(d_src), 32'h2);
        next_cycle(); clr_req();

        // clear statistics, then 17 consecutive stall cycles
        next_cycle(); stat_clr = 1'b1;
        next_cycle(); stat_clr = 1'b0;
        #4 chk("clr_small_cnt", 32'(s_cnt), 32'h0);
        chk("clr_def_cnt", 32'(d_cnt), 32'h0);
        chk("clr_timeout", 32'(s_timeout), 32'h0);
        for (int s = 1; s <= 17; s++) begin
            next_cycle(); set_req(3, 2);
            #4;
            if (s == 3) chk("to_s3", 32'(s_timeout), 32'h0);
            if (s == 4) chk("to_s4", 32'(s_timeout), 32'h1);
        end
        next_cycle(); clr_req();
        #4 chk("wrap_small_cnt", 32'(s_cnt), 32'h1);
        chk("def_cnt17", 32'(d_cnt), 32'd17);
        chk("to_sticky", 32'(s_timeout), 32'h1);
        chk("def_no_timeout", 32'(d_timeout), 32'h0);
        next_cycle();
        #4 chk("to_sticky2", 32'(s_timeout), 32'h1);

        // stat_clr coinciding with a stall wins
        next_cycle(); stat_clr = 1'b1; set_req(4, 1);
        next_cycle(); stat_clr = 1'b0; clr_req();
        #4 chk("clr_pri_cnt", 32'(d_cnt), 32'h0);
        chk("clr_pri_timeout", 32'(s_timeout), 32'h0);
        chk("clr_src", 32'(d_src), 32'h4);

        // reset in the middle of a flush
        next_cycle(); jump_flag = 1'b1;
        #2 chk("rf_flush_pre", 32'(d_flush), 32'h1);
        rst_n = 1'b0;
        #1 chk("rf_flush_async", 32'(s_flush), 32'h0);
        chk("rf_hold_async", 32'(d_hold), 32'h0);
        jump_flag = 1'b0;
        #1 rst_n = 1'b1;
        next_cycle();
        #4 chk("rf_after_flush", 32'(d_flush), 32'h0);
        chk("rf_after_hold", 32'(d_hold), 32'h0);
        chk("rf_after_src", 32'(d_src), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: bench did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pipe_hold_ctrl.md
PIPE_HOLD_CTRL -- requirements
Module: pipe_hold_ctrl

Interface
REQ-001 SHALL have parameter NUM_REQ, default 6, meaning the number of hold requesters (legal range 1..16).
REQ-002 SHALL have parameter NUM_STAGE, default 4, meaning the number of pipeline stages under control; stage 0 is PC, stage 1 is IF, stage 2 is ID, and so on.
REQ-003 SHALL have parameter FLUSH_CYC, default 2, meaning the number of flush cycles per jump (legal range 1..15).
REQ-004 SHALL have parameter STALL_TIMEOUT, default 255, meaning the consecutive-stall cycle count that raises the timeout (legal range 1..65535).
REQ-005 SHALL have parameter CNT_W, default 16, meaning the width of the stall performance counter.
REQ-006 SHALL use local width DW = $clog2(NUM_STAGE+1) and local width SW = $clog2(NUM_REQ), with a minimum of 1 for both.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port hold_req_i, input, NUM_REQ bits: per-requester hold request, level-sensitive.
REQ-010 SHALL have port hold_depth_i, input, NUM_REQ*DW bits: per-requester depth d, held in field [r*DW +: DW].
REQ-011 SHALL have port jump_flag_i, input, 1 bit: a one-cycle redirect pulse.
REQ-012 SHALL have port stat_clr_i, input, 1 bit: synchronous clear of the statistics counter and the timeout flag.
REQ-013 SHALL have port hold_o, output, NUM_STAGE bits: bit k set means stage k is frozen.
REQ-014 SHALL have port flush_o, output, 1 bit: downstream stages insert bubbles.
REQ-015 SHALL have port hold_src_o, output, SW bits: registered index of the winning requester.
REQ-016 SHALL have port timeout_o, output, 1 bit: sticky stall-timeout flag.
REQ-017 SHALL have port stall_cnt_o, output, CNT_W bits: total stalled cycles.

Function
REQ-018 SHALL have requester r, when active, demand a freeze of stages 0..d-1; d=0 is ignored, and d>NUM_STAGE SHALL be clamped to NUM_STAGE.
REQ-019 SHALL drive hold_o[k] combinationally as 1 when any active requester has depth > k, giving zero latency from request to hold; hold_o is therefore always thermometer-shaped (contiguous bits from bit 0).
REQ-020 SHALL implement an FSM with states RUN, FLUSH and STALL.
REQ-021 SHALL treat the FSM as effectively in FLUSH in the same cycle jump_flag_i is sampled high, via a combinational path.
REQ-022 SHALL, in that jump cycle and in the following FLUSH_CYC-1 cycles, assert flush_o=1 and force hold_o to all ones, giving FLUSH_CYC cycles of flush_o in total.
REQ-023 SHALL, when jump_flag_i rises during FLUSH, reload the flush down-counter so that FLUSH_CYC further flush cycles are produced, counting from that jump cycle.
REQ-024 SHALL leave FLUSH for STALL when, at flush end, any depth>0 request is active, and for RUN otherwise.
REQ-025 SHALL move from RUN to STALL on any active request with depth>0, and from STALL to RUN when no such request remains; jump_flag_i has priority over both transitions.
REQ-026 SHALL update hold_src_o every cycle in which an active depth>0 request exists, loading the lowest active index; it SHALL hold its value otherwise.
REQ-027 SHALL increment the consecutive-stall counter (16 bits, saturating at STALL_TIMEOUT) in each cycle where hold_o is nonzero, and clear it in each cycle where hold_o is zero.
REQ-028 SHALL set timeout_o on the cycle after the consecutive-stall counter reaches STALL_TIMEOUT; it SHALL remain set until stat_clr_i is asserted or reset occurs.
REQ-029 SHALL increment stall_cnt_o by 1 in each cycle where hold_o is nonzero, wrapping modulo 2^CNT_W with no saturation.
REQ-030 SHALL, when stat_clr_i and a stall coincide, give stat_clr_i priority: stall_cnt_o becomes 0, not 1, and timeout_o is cleared.
REQ-031 SHALL be independent of hold_src_o and the FSM when producing hold_o; requests arriving during FLUSH change only the next-state decision.

Reset
REQ-032 SHALL, while rst_n=0, immediately set FSM=RUN, flush counter=0, stall counter=0, hold_src_o=0, timeout_o=0 and stall_cnt_o=0; flush_o SHALL be 0 and hold_o SHALL reflect only the live requests.
REQ-033 SHALL, when reset is asserted mid-flush, end the flush instantly; after release, no flush is produced without a new jump_flag_i.

Verification
REQ-034 SHALL verify defaults with req[2]=1, depth=1, and all other requests 0 -> hold_o=4'b0001 in the same cycle, and hold_src_o=2 on the next cycle.
REQ-035 SHALL verify with req[0] depth=3 and req[5] depth=1 -> hold_o=4'b0111 and hold_src_o=0.
REQ-036 SHALL verify a jump pulse at cycle t with no requests -> flush_o=1 and hold_o=4'b1111 at t and t+1, and flush_o=0 and hold_o=0 at t+2.
REQ-037 SHALL verify a second jump at t+1 -> flush_o=1 through t+2 and 0 at t+3.
REQ-038 SHALL verify with STALL_TIMEOUT=3 and a continuous request -> timeout_o=1 from the 4th stall cycle, staying 1 after the request drops, until stat_clr_i is asserted.
REQ-039 SHALL verify CNT_W=4 with 17 stall cycles -> stall_cnt_o=1; rst_n low during flush -> flush_o=0 asynchronously.
